// File: rtl/i281_datamem_scanner.sv
// i281 data-memory scanner: walks the sixteen data-memory bytes of the CPU,
// either on a dwell timer or on manual step edges, and presents the selected
// address/value as registered binary plus active-low seven-segment hex.
// A per-address shadow byte flags values that changed since last shown.
module i281_datamem_scanner #(
  parameter int DWELL_CYCLES = 25000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       scan_en,
  input  logic       step,
  input  logic       hold,
  input  logic [7:0] datamem0,
  input  logic [7:0] datamem1,
  input  logic [7:0] datamem2,
  input  logic [7:0] datamem3,
  input  logic [7:0] datamem4,
  input  logic [7:0] datamem5,
  input  logic [7:0] datamem6,
  input  logic [7:0] datamem7,
  input  logic [7:0] datamem8,
  input  logic [7:0] datamem9,
  input  logic [7:0] datamem10,
  input  logic [7:0] datamem11,
  input  logic [7:0] datamem12,
  input  logic [7:0] datamem13,
  input  logic [7:0] datamem14,
  input  logic [7:0] datamem15,
  output logic [3:0] addr,
  output logic [7:0] value,
  output logic [6:0] hex_addr,
  output logic [6:0] hex_hi,
  output logic [6:0] hex_lo,
  output logic       changed
);

  localparam int CNT_W = $clog2(DWELL_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL_CYCLES - 1);

  typedef enum logic {
    ST_MANUAL = 1'b0,
    ST_SCAN   = 1'b1
  } mode_t;

  mode_t            state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       addr_q, addr_d;
  logic             step_q;
  logic [7:0]       value_q;
  logic             changed_q;
  logic [6:0]       hex_addr_q, hex_hi_q, hex_lo_q;
  logic [7:0]       shadow_q [16];
  logic [7:0]       mem [16];
  logic [7:0]       sel_byte;
  logic             step_edge;
  logic             expire;
  logic             advance;

  // Active-low seven-segment code, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] seg7(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Gather the sixteen byte inputs into an indexable array.
  always_comb begin
    mem[0]  = datamem0;
    mem[1]  = datamem1;
    mem[2]  = datamem2;
    mem[3]  = datamem3;
    mem[4]  = datamem4;
    mem[5]  = datamem5;
    mem[6]  = datamem6;
    mem[7]  = datamem7;
    mem[8]  = datamem8;
    mem[9]  = datamem9;
    mem[10] = datamem10;
    mem[11] = datamem11;
    mem[12] = datamem12;
    mem[13] = datamem13;
    mem[14] = datamem14;
    mem[15] = datamem15;
  end

  assign sel_byte = mem[addr_q];

  // Mode FSM next state, dwell counter and address advance; hold freezes all.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    step_edge = step & ~step_q;
    expire    = 1'b0;
    advance   = 1'b0;
    if (!hold) begin
      state_d = scan_en ? ST_SCAN : ST_MANUAL;
      case (state_q)
        ST_SCAN:   expire = scan_en && (cnt_q == CNT_LAST);
        default:   expire = 1'b0;
      endcase
      // A step edge coinciding with expiry still advances only once.
      advance = step_edge | expire;
      if (advance) begin
        addr_d = addr_q + 4'd1;
      end
      if (advance || (state_d != state_q) || (state_d == ST_MANUAL)) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Control registers; the step history is tracked even while held so a
  // level held across the release of hold does not count as a new edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_SCAN;
      cnt_q   <= '0;
      addr_q  <= 4'd0;
      step_q  <= 1'b0;
    end else begin
      step_q  <= step;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
    end
  end

  // Display registers and shadow bytes, all sampled from the same mux output.
  always_ff @(posedge clock) begin
    if (reset) begin
      value_q    <= 8'h00;
      changed_q  <= 1'b0;
      hex_addr_q <= 7'h40;
      hex_hi_q   <= 7'h40;
      hex_lo_q   <= 7'h40;
      for (int i = 0; i < 16; i++) begin
        shadow_q[i] <= 8'h00;
      end
    end else if (!hold) begin
      value_q    <= sel_byte;
      changed_q  <= (sel_byte != shadow_q[addr_q]);
      hex_addr_q <= seg7(addr_q);
      hex_hi_q   <= seg7(sel_byte[7:4]);
      hex_lo_q   <= seg7(sel_byte[3:0]);
      if (advance) begin
        shadow_q[addr_q] <= value_q;
      end
    end
  end

  assign addr     = addr_q;
  assign value    = value_q;
  assign hex_addr = hex_addr_q;
  assign hex_hi   = hex_hi_q;
  assign hex_lo   = hex_lo_q;
  assign changed  = changed_q;

endmodule

// File: tb/tb_i281_datamem_scanner.sv
// Bench for i281_datamem_scanner: table vectors, directed multi-cycle
// sequences and randomized stimulus against a behavioural reference model.
module tb_i281_datamem_scanner;

  localparam int DW = 4;

  logic       clock = 1'b0;
  logic       reset, scan_en, step, hold;
  logic [7:0] dm [16];
  logic [3:0] addr;
  logic [7:0] value;
  logic [6:0] hex_addr, hex_hi, hex_lo;
  logic       changed;

  i281_datamem_scanner #(.DWELL_CYCLES(DW)) dut (
    .clock(clock), .reset(reset), .scan_en(scan_en), .step(step), .hold(hold),
    .datamem0(dm[0]),   .datamem1(dm[1]),   .datamem2(dm[2]),   .datamem3(dm[3]),
    .datamem4(dm[4]),   .datamem5(dm[5]),   .datamem6(dm[6]),   .datamem7(dm[7]),
    .datamem8(dm[8]),   .datamem9(dm[9]),   .datamem10(dm[10]), .datamem11(dm[11]),
    .datamem12(dm[12]), .datamem13(dm[13]), .datamem14(dm[14]), .datamem15(dm[15]),
    .addr(addr), .value(value), .hex_addr(hex_addr), .hex_hi(hex_hi),
    .hex_lo(hex_lo), .changed(changed)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  logic [6:0] SEG [16];

  typedef struct {
    logic       step;
    logic       hold;
    logic       scan_en;
    logic [3:0] exp_addr;
  } man_vec_t;
  man_vec_t mv [15];

  typedef struct {
    logic [3:0] nib;
    logic [6:0] seg;
  } seg_vec_t;
  seg_vec_t sv [16];

  // Reference model state: what the display should be showing.
  int         m_addr, m_cnt, m_hexa;
  bit         m_scan_prev, m_stepq, m_changed;
  logic [7:0] m_value;
  logic [7:0] m_shadow [16];

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic model_reset();
    m_addr = 0; m_cnt = 0; m_hexa = 0;
    m_scan_prev = 1'b1; m_stepq = 1'b0; m_changed = 1'b0;
    m_value = 8'h00;
    for (int i = 0; i < 16; i++) m_shadow[i] = 8'h00;
  endtask

  // One clock of behaviour, from the inputs present at the edge.
  task automatic model_tick();
    logic [7:0] cur;
    bit edge_ev, expired;
    if (reset) begin
      model_reset();
    end else if (hold) begin
      m_stepq = step;
    end else begin
      edge_ev   = step && !m_stepq;
      expired   = scan_en && m_scan_prev && (m_cnt == DW - 1);
      cur       = dm[m_addr];
      m_changed = (cur != m_shadow[m_addr]);
      m_hexa    = m_addr;
      if (edge_ev || expired) begin
        m_shadow[m_addr] = m_value;
        m_addr = (m_addr + 1) % 16;
        m_cnt  = 0;
      end else if (!scan_en || (scan_en != m_scan_prev)) begin
        m_cnt = 0;
      end else begin
        m_cnt = m_cnt + 1;
      end
      m_value     = cur;
      m_scan_prev = scan_en;
      m_stepq     = step;
    end
  endtask

  task automatic compare_model();
    chk("m_addr", int'(addr), m_addr);
    chk("m_value", int'(value), int'(m_value));
    chk("m_changed", int'(changed), int'(m_changed));
    chk("m_hex_addr", int'(hex_addr), int'(SEG[m_hexa]));
    chk("m_hex_hi", int'(hex_hi), int'(SEG[m_value[7:4]]));
    chk("m_hex_lo", int'(hex_lo), int'(SEG[m_value[3:0]]));
  endtask

  task automatic tick();
    @(posedge clock);
    model_tick();
    #1;
    compare_model();
  endtask

  task automatic pulse();
    step = 1'b1; tick();
    step = 1'b0; tick();
  endtask

  initial begin
    logic [3:0] a0;
    logic [7:0] v0;
    logic [6:0] ha0, hh0, hl0;

    SEG = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    for (int i = 0; i < 16; i++) begin
      sv[i].nib = 4'(i);
      sv[i].seg = SEG[i];
    end
    mv[0]  = '{1'b1, 1'b0, 1'b0, 4'd1};
    mv[1]  = '{1'b0, 1'b0, 1'b0, 4'd1};
    mv[2]  = '{1'b1, 1'b0, 1'b0, 4'd2};
    mv[3]  = '{1'b0, 1'b0, 1'b0, 4'd2};
    mv[4]  = '{1'b1, 1'b0, 1'b0, 4'd3};
    mv[5]  = '{1'b0, 1'b0, 1'b0, 4'd3};
    mv[6]  = '{1'b1, 1'b1, 1'b0, 4'd3};
    mv[7]  = '{1'b1, 1'b0, 1'b0, 4'd3};
    mv[8]  = '{1'b0, 1'b0, 1'b0, 4'd3};
    for (int i = 9; i < 14; i++) mv[i] = '{1'b1, 1'b0, 1'b0, 4'd4};
    mv[14] = '{1'b0, 1'b0, 1'b0, 4'd4};

    reset = 1'b1; scan_en = 1'b1; step = 1'b0; hold = 1'b0;
    for (int i = 0; i < 16; i++) dm[i] = 8'h00;
    model_reset();
    tick(); tick();

    // Reset arriving mid-dwell (counter at 2).
    for (int i = 0; i < 16; i++) dm[i] = 8'(i * 16 + 1);
    reset = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
    chk("rst_addr", int'(addr), 0);
    chk("rst_value", int'(value), 0);
    chk("rst_hex_addr", int'(hex_addr), 'h40);
    chk("rst_hex_hi", int'(hex_hi), 'h40);
    chk("rst_hex_lo", int'(hex_lo), 'h40);
    chk("rst_changed", int'(changed), 0);
    reset = 1'b0;

    // Auto-scan across the wrap, four cycles per address.
    for (int k = 1; k <= 70; k++) begin
      tick();
      chk("scan_addr", int'(addr), (k / 4) % 16);
      if (k == 61) begin
        chk("scan_f_value", int'(value), 'hF1);
        chk("scan_f_hex_hi", int'(hex_hi), 'h0E);
        chk("scan_f_hex_lo", int'(hex_lo), 'h79);
      end
    end

    // Manual stepping from the vector table.
    scan_en = 1'b0; reset = 1'b1; tick(); reset = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step = mv[i].step; hold = mv[i].hold; scan_en = mv[i].scan_en;
      tick();
      chk("tbl_addr", int'(addr), int'(mv[i].exp_addr));
    end
    step = 1'b0; hold = 1'b0;

    // Segment encoding on both nibbles at a fixed address.
    for (int i = 0; i < 16; i++) begin
      dm[4] = {sv[i].nib, 4'(15 - i)};
      tick();
      chk("seg_hi", int'(hex_hi), int'(sv[i].seg));
      chk("seg_lo", int'(hex_lo), int'(sv[15 - i].seg));
    end

    // Step edge coinciding with dwell expiry.
    scan_en = 1'b1; reset = 1'b1; tick(); reset = 1'b0;
    tick(); tick(); tick();
    step = 1'b1; tick();
    chk("sim_addr", int'(addr), 1);
    step = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("sim_dwell", int'(addr), 1);
    end
    tick();
    chk("sim_next", int'(addr), 2);

    // Hold freezes the display while data and step move underneath.
    reset = 1'b1; tick(); reset = 1'b0;
    dm[3] = 8'h12;
    repeat (13) tick();
    chk("hold_pre_addr", int'(addr), 3);
    chk("hold_pre_value", int'(value), 'h12);
    a0 = addr; v0 = value; ha0 = hex_addr; hh0 = hex_hi; hl0 = hex_lo;
    hold = 1'b1; dm[3] = 8'h34;
    for (int i = 0; i < 10; i++) begin
      step = (i % 2 == 1);
      tick();
      chk("hold_addr", int'(addr), int'(a0));
      chk("hold_value", int'(value), int'(v0));
      chk("hold_hex", int'({hex_addr, hex_hi, hex_lo}), int'({ha0, hh0, hl0}));
    end
    hold = 1'b0; step = 1'b0;
    tick();
    chk("hold_release_value", int'(value), 'h34);

    // Change detection against the shadow byte.
    scan_en = 1'b0; reset = 1'b1; tick(); reset = 1'b0;
    dm[5] = 8'hAA;
    repeat (5) pulse();
    chk("cd_visit_addr", int'(addr), 5);
    chk("cd_visit_value", int'(value), 'hAA);
    pulse();
    repeat (15) pulse();
    chk("cd_same_addr", int'(addr), 5);
    chk("cd_same_changed", int'(changed), 0);
    pulse();
    dm[5] = 8'hAB;
    repeat (15) pulse();
    chk("cd_diff_value", int'(value), 'hAB);
    chk("cd_diff_changed", int'(changed), 1);
    chk("cd_diff_hex_lo", int'(hex_lo), 'h03);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(0, 63) == 0);
      hold  = ($urandom_range(0, 5) == 0);
      step  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 23) == 0) scan_en = ~scan_en;
      if ($urandom_range(0, 3) == 0) dm[$urandom_range(0, 15)] = 8'($urandom);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/i281_datamem_scanner.md
Name: i281_datamem_scanner

Overview:
Display-side consumer of the i281 multicycle CPU's sixteen data-memory byte outputs (datamem0..datamem15). It steps through the 16 bytes, either automatically on a dwell timer or manually with a step input, and presents the selected address and value as registered binary and active-low seven-segment hex. A per-address shadow copy raises a change flag when a byte differs from the value last shown at that address. It sits between i281_toplevel and the board display pins.

Parameters:
DWELL_CYCLES, 25000000, clock cycles each address is shown in auto-scan mode; must be ≥ 2; benches use 4.

Ports:
clock  input  1  system clock; the block has one clock.
reset  input  1  reset is synchronous and active-high.
scan_en  input  1  1 = auto-scan mode; 0 = manual mode.
step  input  1  level input, synchronous to clock; each rising edge advances the address.
hold  input  1  1 = freeze the address, counter and all display outputs.
datamem0..datamem15  input  8 each  live data-memory bytes from i281_toplevel.
addr  output  4  currently selected address.
value  output  8  registered copy of datamem[addr].
hex_addr  output  7  seven-segment code of addr.
hex_hi  output  7  seven-segment code of value[7:4].
hex_lo  output  7  seven-segment code of value[3:0].
changed  output  1  1 when value differs from the shadow byte stored for addr.

Behaviour:
- Segment encoding: active-low, bit order {g,f,e,d,c,b,a}; 0→7'h40, 1→7'h79, 2→7'h24, 3→7'h30, 4→7'h19, 5→7'h12, 6→7'h02, 7→7'h78, 8→7'h00, 9→7'h10, A→7'h08, b→7'h03, C→7'h46, d→7'h21, E→7'h06, F→7'h0E.
- Reset (when reset=1 at a clock edge), all of the following:
  - addr=0, dwell counter=0, value=0, changed=0.
  - All 16 shadow bytes cleared to 0.
  - hex_addr, hex_hi and hex_lo all 7'h40.
  - step edge register cleared to 0.
  - Reset has priority over every other input and may arrive mid-dwell.
- State machine, re-evaluated every cycle from scan_en:
  - SCAN (scan_en=1): the counter increments each non-hold cycle. When the counter equals DWELL_CYCLES-1, addr advances and the counter clears.
  - MANUAL (scan_en=0): the counter is held at 0.
  - Any change of mode clears the counter on that cycle.
- Step edge: step_q is registered every cycle. An edge is step=1 and step_q=0.
  - An edge advances addr in either mode.
  - In SCAN mode an edge also clears the counter.
  - If an edge and dwell expiry fall on the same cycle, addr advances exactly once.
- Advance rule: addr ← addr+1 mod 16, so 15 wraps to 0.
  - On the advancing edge, shadow[old addr] ← current value.
- Hold (hold=1):
  - addr, counter, value, changed, hex outputs and shadow are all frozen.
  - Step edges during hold are ignored, but step_q still tracks step, so a step held high through the release of hold does not re-trigger.
- Data path, when hold=0:
  - value ← datamem[addr], where addr is the registered value at the start of the cycle.
  - hex_hi and hex_lo are registered from that same mux output, so they are aligned with value.
  - hex_addr ← encode(addr).
  - Latency: one clock after addr changes, value and hex reflect the new byte.
  - Live changes on datamem inputs propagate to value with 1-cycle latency while the address is held.
- changed ← (datamem[addr] != shadow[addr]), registered in the same cycle as value.

Test Plan:
- Reset mid-dwell: DWELL_CYCLES=4, scan_en=1, reset asserted at counter=2 → next edge: addr=0, value=0, all hex outputs 7'h40, changed=0.
- Auto-scan wrap: datamem_n=n*16+1, scan_en=1, 70 cycles.
  - addr sequence 0,1,…,15,0, each address held 4 cycles.
  - At addr=15, value=8'hF1 one cycle later, with hex_hi=7'h0E and hex_lo=7'h79.
- Manual step: scan_en=0, three 1-cycle step pulses, then step held high for 5 cycles.
  - addr advances 0→1→2→3 on the pulses.
  - The held level produces exactly one advance, to 4.
- Simultaneous events: scan_en=1, step edge on the counter=3 cycle → addr advances by exactly 1 and the counter restarts at 0.
- Hold: hold=1 for 10 cycles in SCAN mode while datamem3 changes 8'h12→8'h34 and step pulses.
  - addr, value and hex are unchanged throughout.
  - After release, value=8'h34 one cycle later.
- Change detect:
  - Visit addr 5 with datamem5=8'hAA, then advance; shadow[5] becomes 8'hAA.
  - Set datamem5=8'hAB and step through the 16 addresses to return to 5: changed=1, hex_lo=7'h03.
  - Return with datamem5=8'hAA instead: changed=0.
